// File: rtl/sram_march_bist.sv
// March C- self-test engine driving a single-port SRAM; reports pass/fail,
// first failing address/element and a saturating mismatch count.
//
// state | meaning
// IDLE  | waiting for start after reset
// W0    | element E0, ascending write of all zeros
// RW    | elements E1..E4, read phase then write phase per address
// RD    | element E5, ascending read-only sweep
// DRAIN | no request; compares the last E5 read
// DONE  | results held until the next start
module sram_march_bist #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned NUM_WORDS    = 1024,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         fail_o,
  output logic [$clog2(NUM_WORDS)-1:0] fail_addr_o,
  output logic [2:0]                   fail_elem_o,
  output logic [15:0]                  err_count_o,
  output logic                         req_o,
  output logic                         we_o,
  output logic [$clog2(NUM_WORDS)-1:0] addr_o,
  output logic [DATA_WIDTH-1:0]        wdata_o,
  output logic [DATA_WIDTH/8-1:0]      be_o,
  input  logic [DATA_WIDTH-1:0]        rdata_i
);

  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_W0    = 3'd1;
  localparam logic [2:0] S_RW    = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            state_q, state_n;
  logic [2:0]            elem_q, elem_n;
  logic                  phase_q, phase_n;
  logic [AW-1:0]         addr_q, addr_n;

  logic                  cmp_valid_q;
  logic [AW-1:0]         cmp_addr_q;
  logic [2:0]            cmp_elem_q;

  logic                  down_dir;
  logic                  at_end;
  logic                  start_ok;
  logic                  in_test;
  logic                  in_test_n;
  logic                  mismatch;
  logic                  req_n;
  logic                  we_n;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [DATA_WIDTH-1:0] pattern_n;

  assign down_dir = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign at_end   = down_dir ? (addr_q == '0) : (addr_q == LAST_ADDR);
  assign start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign in_test  = (state_q == S_W0) || (state_q == S_RW) ||
                    (state_q == S_RD) || (state_q == S_DRAIN);

  // Reads in E2 and E4 expect ones; every other read expects zeros.
  assign exp_data = ((cmp_elem_q == 3'd2) || (cmp_elem_q == 3'd4)) ?
                    {DATA_WIDTH{1'b1}} : '0;
  assign mismatch = cmp_valid_q && in_test && (rdata_i != exp_data);

  always_comb begin
    state_n = state_q;
    elem_n  = elem_q;
    phase_n = phase_q;
    addr_n  = addr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_n = S_W0;
          elem_n  = 3'd0;
          phase_n = 1'b0;
          addr_n  = '0;
        end
      end
      S_W0: begin
        if (addr_q == LAST_ADDR) begin
          state_n = S_RW;
          elem_n  = 3'd1;
          phase_n = 1'b0;
          addr_n  = '0;
        end else begin
          addr_n = addr_q + AW'(1);
        end
      end
      S_RW: begin
        if (!phase_q) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (at_end) begin
            if (elem_q == 3'd4) begin
              state_n = S_RD;
              elem_n  = 3'd5;
              addr_n  = '0;
            end else begin
              elem_n = elem_q + 3'd1;
              addr_n = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LAST_ADDR : '0;
            end
          end else begin
            addr_n = down_dir ? (addr_q - AW'(1)) : (addr_q + AW'(1));
          end
        end
      end
      S_RD: begin
        if (addr_q == LAST_ADDR) begin
          state_n = S_DRAIN;
          addr_n  = '0;
        end else begin
          addr_n = addr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        state_n = S_DONE;
      end
      default: begin
        state_n = S_IDLE;
        elem_n  = 3'd0;
        phase_n = 1'b0;
        addr_n  = '0;
      end
    endcase
    // Abort: the write already on the bus completes, nothing new is issued.
    if (STOP_ON_FAIL && mismatch) begin
      state_n = S_DONE;
      phase_n = 1'b0;
      addr_n  = '0;
    end
  end

  assign in_test_n = (state_n == S_W0) || (state_n == S_RW) ||
                     (state_n == S_RD) || (state_n == S_DRAIN);
  assign req_n     = (state_n == S_W0) || (state_n == S_RW) || (state_n == S_RD);
  assign we_n      = (state_n == S_W0) || ((state_n == S_RW) && phase_n);
  assign pattern_n = ((elem_n == 3'd1) || (elem_n == 3'd3)) ?
                     {DATA_WIDTH{1'b1}} : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      elem_q  <= 3'd0;
      phase_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_n;
      elem_q  <= elem_n;
      phase_q <= phase_n;
      addr_q  <= addr_n;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      req_o       <= 1'b0;
      we_o        <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= '0;
      be_o        <= '0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= 3'd0;
    end else begin
      busy_o      <= in_test_n;
      done_o      <= (state_n == S_DONE);
      req_o       <= req_n;
      we_o        <= we_n;
      addr_o      <= req_n ? addr_n : '0;
      wdata_o     <= we_n ? pattern_n : '0;
      be_o        <= req_n ? '1 : '0;
      // A read on the bus this cycle returns data to compare next cycle.
      cmp_valid_q <= req_o && !we_o;
      cmp_addr_q  <= addr_o;
      cmp_elem_q  <= elem_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_elem_o <= 3'd0;
      err_count_o <= 16'd0;
    end else if (start_ok) begin
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_elem_o <= 3'd0;
      err_count_o <= 16'd0;
    end else if (mismatch) begin
      if (err_count_o != 16'hFFFF) begin
        err_count_o <= err_count_o + 16'd1;
      end
      if (!fail_o) begin
        fail_o      <= 1'b1;
        fail_addr_o <= cmp_addr_q;
        fail_elem_o <= cmp_elem_q;
      end
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: two DUTs (run-to-completion and stop-on-fail), each
// with a 1-cycle SRAM model carrying an optional stuck-at bit, checked against a march model.
module tb_sram_march_bist;

  localparam int N = 16;
  localparam int W = 32;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic start0, start1;

  logic        busy0, done0, fail0, req0, we0;
  logic [3:0]  faddr0, addr0, be0;
  logic [2:0]  felem0;
  logic [15:0] err0;
  logic [31:0] wdata0, rdata0;

  logic        busy1, done1, fail1, req1, we1;
  logic [3:0]  faddr1, addr1, be1;
  logic [2:0]  felem1;
  logic [15:0] err1;
  logic [31:0] wdata1, rdata1;

  logic [31:0] mem0 [N];
  logic [31:0] mem1 [N];
  logic [3:0]  raddr0 = 4'd0;
  logic [3:0]  raddr1 = 4'd0;

  bit f_en = 1'b0;
  int f_addr = 0;
  int f_bit = 0;
  bit f_val = 1'b0;

  int checks = 0;
  int passed = 0;
  int edge_cnt = 0;
  int be_err = 0;
  int rad0 = 0;
  int rad1 = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  sram_march_bist #(.DATA_WIDTH(W), .NUM_WORDS(N), .STOP_ON_FAIL(1'b0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start0),
    .busy_o(busy0), .done_o(done0), .fail_o(fail0),
    .fail_addr_o(faddr0), .fail_elem_o(felem0), .err_count_o(err0),
    .req_o(req0), .we_o(we0), .addr_o(addr0), .wdata_o(wdata0), .be_o(be0),
    .rdata_i(rdata0)
  );

  sram_march_bist #(.DATA_WIDTH(W), .NUM_WORDS(N), .STOP_ON_FAIL(1'b1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start1),
    .busy_o(busy1), .done_o(done1), .fail_o(fail1),
    .fail_addr_o(faddr1), .fail_elem_o(felem1), .err_count_o(err1),
    .req_o(req1), .we_o(we1), .addr_o(addr1), .wdata_o(wdata1), .be_o(be1),
    .rdata_i(rdata1)
  );

  function automatic logic [31:0] flt(input logic [3:0] a, input logic [31:0] v,
                                      input bit en, input int fa, input int fb, input bit fv);
    logic [31:0] r;
    r = v;
    if (en && int'(a) == fa) r[fb] = fv;
    return r;
  endfunction

  always @(posedge clk_i) begin
    if (req0) begin
      if (we0) mem0[addr0] <= flt(addr0, wdata0, f_en, f_addr, f_bit, f_val);
      else     raddr0 <= addr0;
    end
    if (req1) begin
      if (we1) mem1[addr1] <= flt(addr1, wdata1, f_en, f_addr, f_bit, f_val);
      else     raddr1 <= addr1;
    end
  end
  assign rdata0 = flt(raddr0, mem0[raddr0], f_en, f_addr, f_bit, f_val);
  assign rdata1 = flt(raddr1, mem1[raddr1], f_en, f_addr, f_bit, f_val);

  always @(negedge clk_i) begin
    if (req0 && be0 !== 4'hF) be_err++;
    if (!req0 && be0 !== 4'h0) be_err++;
    if (req1 && be1 !== 4'hF) be_err++;
    if (!req1 && be1 !== 4'h0) be_err++;
    if (done0 && req0) rad0++;
    if (done1 && req1) rad1++;
  end

  // March C- walked element by element on a plain array; cycle 0 is the first E0 write.
  task automatic run_model(input bit fen, input int fa, input int fb, input bit fv, input bit stop,
                           output int e_err, output bit e_fail, output int e_addr,
                           output int e_elem, output int e_off);
    logic [31:0] m [N];
    logic [31:0] v, expv, wv;
    int t, a, first_t;
    bit stopped;
    e_err = 0; e_fail = 0; e_addr = 0; e_elem = 0; first_t = 0; stopped = 0; t = 0;
    for (int i = 0; i < N; i++) begin m[i] = 32'h0; t++; end
    for (int e = 1; e <= 5 && !stopped; e++) begin
      expv = (e == 2 || e == 4) ? 32'hFFFF_FFFF : 32'h0;
      wv   = (e == 1 || e == 3) ? 32'hFFFF_FFFF : 32'h0;
      for (int j = 0; j < N && !stopped; j++) begin
        a = (e == 3 || e == 4) ? N - 1 - j : j;
        v = m[a];
        if (fen && a == fa) v[fb] = fv;
        t++;
        if (v !== expv) begin
          if (!e_fail) begin e_fail = 1; e_addr = a; e_elem = e; first_t = t; end
          if (e_err < 65535) e_err++;
          if (stop) stopped = 1;
        end
        if (e < 5) begin m[a] = wv; t++; end
      end
    end
    e_off = stopped ? first_t + 1 : t + 1;
  endtask

  task automatic run_test(input bit sel, input int pre, input bit toggle,
                          output int off, output bit tmo, output int gaps,
                          output logic [17:0] first_status);
    int k;
    repeat (pre) @(negedge clk_i);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    k = edge_cnt + 1;
    @(negedge clk_i);
    start0 = 1'b0; start1 = 1'b0;
    first_status = sel ? {done1, fail1, err1} : {done0, fail0, err0};
    tmo = 1'b1; gaps = 0; off = 0;
    for (int i = 0; i < 400; i++) begin
      if (sel ? done1 : done0) begin tmo = 1'b0; off = edge_cnt - k; break; end
      if (!(sel ? busy1 : busy0)) gaps++;
      if (toggle && i >= 2 && i < 140) begin
        if (sel) start1 = 1'($urandom_range(0, 1)); else start0 = 1'($urandom_range(0, 1));
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      @(negedge clk_i);
    end
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({busy0, done0, fail0, faddr0, felem0, err0} !== 26'h0)
      $display("FAIL reset_status0: got %h want 0", {busy0, done0, fail0, faddr0, felem0, err0});
    else passed++;
    checks++;
    if ({req0, we0, addr0, wdata0, be0} !== 42'h0)
      $display("FAIL reset_sram0: got %h want 0", {req0, we0, addr0, wdata0, be0});
    else passed++;
    checks++;
    if ({busy1, done1, fail1, err1, req1, we1, be1} !== 25'h0)
      $display("FAIL reset_dut1: got %h want 0", {busy1, done1, fail1, err1, req1, we1, be1});
    else passed++;
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({busy0, done0, req0, busy1, done1, req1} !== 6'h0)
      $display("FAIL idle_after_reset: got %b want 000000", {busy0, done0, req0, busy1, done1, req1});
    else passed++;
  endtask

  task automatic test_clean_run();
    int e_err, e_addr, e_elem, e_off, off, gaps, be0_snap;
    bit e_fail, tmo;
    logic [17:0] fs;
    f_en = 1'b0;
    run_model(1'b0, 0, 0, 1'b0, 1'b0, e_err, e_fail, e_addr, e_elem, e_off);
    be0_snap = be_err;
    run_test(1'b0, int'($urandom_range(0, 5)), 1'b0, off, tmo, gaps, fs);
    checks++;
    if (tmo || off !== e_off) $display("FAIL clean_latency: got %0d (timeout %0d) want %0d", off, tmo, e_off);
    else passed++;
    checks++;
    if (gaps !== 0) $display("FAIL clean_busy: busy low %0d cycles want 0", gaps);
    else passed++;
    checks++;
    if (fail0 !== e_fail || err0 !== 16'(e_err))
      $display("FAIL clean_status: got fail=%b err=%0d want fail=%b err=%0d", fail0, err0, e_fail, e_err);
    else passed++;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (mem0[i] !== 32'h0) $display("FAIL clean_mem[%0d]: got %h want 0", i, mem0[i]);
      else passed++;
    end
    checks++;
    if (be_err - be0_snap !== 0) $display("FAIL clean_be: got %0d bad be cycles want 0", be_err - be0_snap);
    else passed++;
  endtask

  task automatic test_stuck_at(input bit sel, input int fa, input int fb, input bit fv);
    int e_err, e_addr, e_elem, e_off, off, gaps, rad_snap;
    bit e_fail, tmo;
    logic [17:0] fs;
    f_en = 1'b1; f_addr = fa; f_bit = fb; f_val = fv;
    run_model(1'b1, fa, fb, fv, sel, e_err, e_fail, e_addr, e_elem, e_off);
    rad_snap = sel ? rad1 : rad0;
    run_test(sel, int'($urandom_range(0, 3)), 1'b0, off, tmo, gaps, fs);
    checks++;
    if (tmo || off !== e_off)
      $display("FAIL sa%0d_latency dut%0d a=%0d b=%0d: got %0d (timeout %0d) want %0d", fv, sel, fa, fb, off, tmo, e_off);
    else passed++;
    checks++;
    if ((sel ? fail1 : fail0) !== e_fail)
      $display("FAIL sa_fail dut%0d a=%0d b=%0d: got %b want %b", sel, fa, fb, sel ? fail1 : fail0, e_fail);
    else passed++;
    checks++;
    if ((sel ? faddr1 : faddr0) !== e_addr[3:0])
      $display("FAIL sa_fail_addr dut%0d: got %0d want %0d", sel, sel ? faddr1 : faddr0, e_addr);
    else passed++;
    checks++;
    if ((sel ? felem1 : felem0) !== e_elem[2:0])
      $display("FAIL sa_fail_elem dut%0d: got %0d want %0d", sel, sel ? felem1 : felem0, e_elem);
    else passed++;
    checks++;
    if ((sel ? err1 : err0) !== 16'(e_err))
      $display("FAIL sa_err_count dut%0d: got %0d want %0d", sel, sel ? err1 : err0, e_err);
    else passed++;
    repeat (20) @(negedge clk_i);
    checks++;
    if ((sel ? rad1 : rad0) - rad_snap !== 0)
      $display("FAIL sa_req_after_done dut%0d: got %0d want 0", sel, (sel ? rad1 : rad0) - rad_snap);
    else passed++;
  endtask

  task automatic test_random_faults();
    for (int n = 0; n < 6; n++) begin
      test_stuck_at(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                    int'($urandom_range(0, W - 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    int e_err, e_addr, e_elem, e_off, off, gaps;
    bit e_fail, tmo;
    logic [17:0] fs;
    f_en = 1'b1; f_addr = 7; f_bit = 5; f_val = 1'b1;
    @(negedge clk_i);
    start0 = 1'b1;
    @(negedge clk_i);
    start0 = 1'b0;
    repeat (49) @(negedge clk_i);
    checks++;
    if (fail0 !== 1'b1) $display("FAIL mid_fail_before_reset: got %b want 1", fail0);
    else passed++;
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({req0, busy0, done0, fail0, err0, faddr0, felem0} !== 26'h0)
      $display("FAIL mid_reset_outputs: got %h want 0", {req0, busy0, done0, fail0, err0, faddr0, felem0});
    else passed++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    f_en = 1'b0;
    run_model(1'b0, 0, 0, 1'b0, 1'b0, e_err, e_fail, e_addr, e_elem, e_off);
    run_test(1'b0, 2, 1'b0, off, tmo, gaps, fs);
    checks++;
    if (tmo || off !== e_off) $display("FAIL mid_rerun_latency: got %0d (timeout %0d) want %0d", off, tmo, e_off);
    else passed++;
    checks++;
    if (fail0 !== 1'b0 || err0 !== 16'h0) $display("FAIL mid_rerun_status: got fail=%b err=%0d want 0 0", fail0, err0);
    else passed++;
    checks++;
    begin
      int nz = 0;
      for (int i = 0; i < N; i++) if (mem0[i] !== 32'h0) nz++;
      if (nz !== 0) $display("FAIL mid_rerun_mem: got %0d nonzero words want 0", nz);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int e_err, e_addr, e_elem, e_off, off, gaps;
    bit e_fail, tmo;
    logic [17:0] fs;
    f_en = 1'b1; f_addr = 7; f_bit = 5; f_val = 1'b1;
    run_test(1'b0, 1, 1'b0, off, tmo, gaps, fs);
    checks++;
    if (tmo || fail0 !== 1'b1) $display("FAIL b2b_first_fail: got %b (timeout %0d) want 1", fail0, tmo);
    else passed++;
    f_en = 1'b0;
    run_model(1'b0, 0, 0, 1'b0, 1'b0, e_err, e_fail, e_addr, e_elem, e_off);
    run_test(1'b0, 0, 1'b1, off, tmo, gaps, fs);
    checks++;
    if (fs !== 18'h0) $display("FAIL b2b_restart_clear: got {done,fail,err}=%h want 0", fs);
    else passed++;
    checks++;
    if (tmo || off !== e_off) $display("FAIL b2b_latency: got %0d (timeout %0d) want %0d", off, tmo, e_off);
    else passed++;
    checks++;
    if (gaps !== 0) $display("FAIL b2b_busy: busy low %0d cycles want 0", gaps);
    else passed++;
    checks++;
    if (fail0 !== e_fail || err0 !== 16'(e_err))
      $display("FAIL b2b_status: got fail=%b err=%0d want fail=%b err=%0d", fail0, err0, e_fail, e_err);
    else passed++;
  endtask

  initial begin
    start0 = 1'b0;
    start1 = 1'b0;
    test_reset();
    test_clean_run();
    test_stuck_at(1'b0, 7, 5, 1'b1);
    test_stuck_at(1'b0, 0, 0, 1'b0);
    test_stuck_at(1'b1, 7, 5, 1'b1);
    test_random_faults();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk_i);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
